// File: rtl/mmio_timer_pkg.sv
// mmio_timer_pkg
//   Shared definitions for the memory-mapped timer: register offsets within
//   the 32-byte window, CTRL bit positions and the CTRL register layout.
package mmio_timer_pkg;

    // Word offsets inside the window. addr[1:0] is ignored, so these are
    // compared against {addr[4:2], 2'b00}.
    localparam logic [4:0] OFF_CTRL     = 5'h00;
    localparam logic [4:0] OFF_PRESCALE = 5'h04;
    localparam logic [4:0] OFF_COUNT    = 5'h08;
    localparam logic [4:0] OFF_COMPARE  = 5'h0C;
    localparam logic [4:0] OFF_STATUS   = 5'h10;

    // CTRL bit indices.
    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_IE = 2;

    // Packed so that {ie, ar, en} lines up with CTRL bits [2:0].
    typedef struct packed {
        logic ie;
        logic ar;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/mmio_timer_prescaler.sv
// timer_prescaler
//   Divides the clock by (div_i + 1) while enabled and emits a one-cycle tick.
//   Ports:
//     clk_i   clock
//     rst_ni  synchronous active-low reset; clears the divider count
//     en_i    count enable; when low the divider count holds
//     clr_i   restart the divider (PRESCALE written); suppresses the tick
//     div_i   divide value; a tick occurs every div_i+1 enabled cycles
//     tick_o  combinational tick, high in the cycle the divider wraps
module timer_prescaler #(
    parameter int PRE_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [PRE_W-1:0] div_i,
    output logic             tick_o
);

    logic [PRE_W-1:0] pre_cnt;

    // A PRESCALE write restarts the divide period, so no tick that cycle.
    assign tick_o = en_i && !clr_i && (pre_cnt == div_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pre_cnt <= '0;
        end else if (clr_i) begin
            pre_cnt <= '0;
        end else if (en_i) begin
            if (pre_cnt == div_i) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// mmio_timer
//   Word-only memory-mapped timer on the LSU data bus. Loads are answered
//   combinationally in the same cycle; stores take effect at the clock edge.
//   Bus semantics: there is no valid/ready handshake. A store is accepted in
//   exactly the cycle where we_i & hit_o is high; a load is any cycle with
//   hit_o high and the LSU simply samples rdata_o. The bus never stalls.
//   Ports:
//     clk_i    clock
//     rst_ni   synchronous active-low reset
//     addr_i   byte address from the LSU
//     wdata_i  store data
//     we_i     store strobe
//     rdata_o  load data, 0 outside the window
//     hit_o    address falls in the 32-byte window at BASE_ADDR
//     irq_o    level interrupt: STATUS.MATCH & CTRL.IRQ_EN
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7040,
    parameter int          PRE_W     = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        we_i,
    output logic [31:0] rdata_o,
    output logic        hit_o,
    output logic        irq_o
);

    ctrl_t            ctrl;
    logic [PRE_W-1:0] prescale;
    logic [31:0]      count;
    logic [31:0]      compare;
    logic             match;

    logic [4:0] off;
    logic       wr;
    logic       wr_ctrl, wr_pre, wr_count, wr_cmp, wr_status;
    logic       tick;
    logic       cmp_eq;
    logic       unused_addr_lsb;

    assign hit_o           = (addr_i[31:5] == BASE_ADDR[31:5]);
    assign off             = {addr_i[4:2], 2'b00};
    assign unused_addr_lsb = ^addr_i[1:0];
    assign wr              = we_i && hit_o;

    assign wr_ctrl   = wr && (off == OFF_CTRL);
    assign wr_pre    = wr && (off == OFF_PRESCALE);
    assign wr_count  = wr && (off == OFF_COUNT);
    assign wr_cmp    = wr && (off == OFF_COMPARE);
    assign wr_status = wr && (off == OFF_STATUS);

    // Compare always uses the pre-edge COUNT and COMPARE, so a same-cycle
    // store to either does not affect this cycle's match decision.
    assign cmp_eq = (count == compare);

    timer_prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (ctrl.en),
        .clr_i  (wr_pre),
        .div_i  (prescale),
        .tick_o (tick)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ctrl     <= '0;
            prescale <= '0;
            count    <= '0;
            compare  <= '0;
            match    <= 1'b0;
        end else begin
            // CTRL: a software store overrides the one-shot auto-disable.
            if (wr_ctrl) begin
                ctrl <= ctrl_t'(wdata_i[2:0]);
            end else if (tick && cmp_eq && !ctrl.ar) begin
                ctrl.en <= 1'b0;
            end

            if (wr_pre) begin
                prescale <= wdata_i[PRE_W-1:0];
            end

            if (wr_cmp) begin
                compare <= wdata_i;
            end

            // COUNT: a software store wins over the tick update.
            if (wr_count) begin
                count <= wdata_i;
            end else if (tick) begin
                if (cmp_eq) begin
                    if (ctrl.ar) begin
                        count <= '0;
                    end
                end else begin
                    count <= count + 32'd1;
                end
            end

            // MATCH: setting has priority over write-1-to-clear.
            if (tick && cmp_eq) begin
                match <= 1'b1;
            end else if (wr_status && wdata_i[0]) begin
                match <= 1'b0;
            end
        end
    end

    assign irq_o = match && ctrl.ie;

    always_comb begin
        rdata_o = '0;
        if (hit_o) begin
            case (off)
                OFF_CTRL:     rdata_o = {29'd0, ctrl};
                OFF_PRESCALE: rdata_o = {{(32-PRE_W){1'b0}}, prescale};
                OFF_COUNT:    rdata_o = count;
                OFF_COMPARE:  rdata_o = compare;
                OFF_STATUS:   rdata_o = {31'd0, match};
                default:      rdata_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer
//   Directed bench for mmio_timer. Stores are driven for exactly one clock
//   edge; loads are sampled 1 ns after driving the address, well away from
//   the rising edge. Expected values are pushed into exp_q and popped when
//   the corresponding DUT output is sampled.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_7040;
    localparam logic [4:0] O_CTRL = 5'h00;
    localparam logic [4:0] O_PRE  = 5'h04;
    localparam logic [4:0] O_CNT  = 5'h08;
    localparam logic [4:0] O_CMP  = 5'h0C;
    localparam logic [4:0] O_STS  = 5'h10;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;

    logic [31:0] exp_q[$];
    int          tests_run;
    int          fail_cnt;

    mmio_timer dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .addr_i  (addr),
        .wdata_i (wdata),
        .we_i    (we),
        .rdata_o (rdata),
        .hit_o   (hit),
        .irq_o   (irq)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] got);
        logic [31:0] exp;
        tests_run++;
        if (exp_q.size() == 0) begin
            fail_cnt++;
            $display("FAIL %s: got %h but no expected value queued", tag, got);
        end else begin
            exp = exp_q.pop_front();
            assert (got === exp) else begin
                fail_cnt++;
                $error("FAIL %s: got %h expected %h", tag, got, exp);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus_write(input logic [4:0] off, input logic [31:0] data);
        addr  = BASE + {27'd0, off};
        wdata = data;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        addr = a;
        we   = 1'b0;
        #1;
        check(tag, rdata);
        addr = 32'h0;
    endtask

    task automatic reg_read(input logic [4:0] off, input logic [31:0] exp, input string tag);
        bus_read(BASE + {27'd0, off}, exp, tag);
    endtask

    task automatic irq_check(input logic exp, input string tag);
        exp_q.push_back({31'd0, exp});
        #1;
        check(tag, {31'd0, irq});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        tests_run = 0;
        fail_cnt  = 0;
        rst_n = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        we    = 1'b0;
        wait_cycles(3);
        rst_n = 1'b1;

        // 1. reset state, window decode, unused bits / offsets
        for (int i = 0; i < 8; i++) begin
            reg_read(5'(i * 4), 32'h0, $sformatf("reset_rd_%0d", i));
        end
        irq_check(1'b0, "reset_irq");
        exp_q.push_back(32'd1);
        addr = BASE + 32'h8;
        #1;
        check("hit_in_window", {31'd0, hit});
        exp_q.push_back(32'd0);
        addr = BASE + 32'h20;
        #1;
        check("hit_past_window", {31'd0, hit});
        bus_read(BASE + 32'h20, 32'h0, "rd_past_window");
        bus_read(32'h0000_1008, 32'h0, "rd_outside");
        bus_write(5'h14, 32'hDEAD_BEEF);
        reg_read(5'h14, 32'h0, "rsvd_write_ignored");
        bus_write(O_CTRL, 32'hFFFF_FFF8);
        reg_read(O_CTRL, 32'h0, "ctrl_upper_bits");
        bus_write(O_PRE, 32'hABCD_1234);
        reg_read(O_PRE, 32'h0000_1234, "prescale_upper_bits");

        // 2. prescaled counting: one increment every 4 cycles
        bus_write(O_PRE, 32'd3);
        bus_write(O_CMP, 32'hFFFF_FFFF);
        bus_write(O_CTRL, 32'h1);
        wait_cycles(19);
        reg_read(O_CNT, 32'd4, "pre3_count_19");
        wait_cycles(1);
        reg_read(O_CNT, 32'd5, "pre3_count_20");
        bus_write(O_CTRL, 32'h0);

        // 3. auto-reload with interrupt
        bus_write(O_CNT, 32'd0);
        bus_write(O_PRE, 32'd0);
        bus_write(O_CMP, 32'd4);
        bus_write(O_CTRL, 32'h7);
        reg_read(O_CNT, 32'd0, "ar_count_0");
        for (int k = 1; k <= 7; k++) begin
            wait_cycles(1);
            reg_read(O_CNT, 32'(k % 5), $sformatf("ar_count_%0d", k));
            reg_read(O_STS, (k >= 5) ? 32'd1 : 32'd0, $sformatf("ar_match_%0d", k));
            irq_check(k >= 5, $sformatf("ar_irq_%0d", k));
        end
        bus_write(O_STS, 32'h1);
        reg_read(O_STS, 32'd0, "w1c_match");
        irq_check(1'b0, "w1c_irq");
        bus_write(O_CTRL, 32'h0);

        // 4. one-shot
        bus_write(O_CNT, 32'd0);
        bus_write(O_CMP, 32'd2);
        bus_write(O_CTRL, 32'h1);
        wait_cycles(3);
        reg_read(O_CNT, 32'd2, "os_count");
        reg_read(O_STS, 32'd1, "os_match");
        reg_read(O_CTRL, 32'd0, "os_ctrl_cleared");
        irq_check(1'b0, "os_irq_masked");
        wait_cycles(10);
        bus_read(BASE + 32'h0A, 32'd2, "os_count_hold");

        // 5a. COUNT store in a tick cycle
        bus_write(O_STS, 32'h1);
        bus_write(O_CNT, 32'd0);
        bus_write(O_CMP, 32'hFFFF_FFFF);
        bus_write(O_CTRL, 32'h1);
        wait_cycles(2);
        reg_read(O_CNT, 32'd2, "col_pre_count");
        bus_write(O_CNT, 32'h100);
        reg_read(O_CNT, 32'h100, "col_count_write");
        wait_cycles(1);
        reg_read(O_CNT, 32'h101, "col_count_after");
        bus_write(O_CTRL, 32'h0);

        // 5b. wrap 0xFFFF_FFFF -> 0 without a match
        bus_write(O_CNT, 32'hFFFF_FFFF);
        bus_write(O_CMP, 32'd5);
        bus_write(O_CTRL, 32'h1);
        wait_cycles(1);
        reg_read(O_CNT, 32'd0, "wrap_count");
        reg_read(O_STS, 32'd0, "wrap_no_match");

        // 5c. W1C collides with a match: set wins
        wait_cycles(5);
        reg_read(O_CNT, 32'd5, "w1c_col_pre");
        bus_write(O_STS, 32'h1);
        reg_read(O_STS, 32'd1, "w1c_col_match");
        reg_read(O_CTRL, 32'd0, "w1c_col_ctrl");
        reg_read(O_CNT, 32'd5, "w1c_col_count");

        // 5d. CTRL store in a one-shot match cycle: store wins
        bus_write(O_CTRL, 32'h1);
        bus_write(O_CTRL, 32'h1);
        reg_read(O_CTRL, 32'd1, "ctrl_col_en");
        reg_read(O_CNT, 32'd5, "ctrl_col_count");

        // 6. reset while counting
        bus_write(O_CTRL, 32'h0);
        bus_write(O_CNT, 32'h37);
        bus_write(O_CMP, 32'hFFFF_FFFF);
        bus_write(O_PRE, 32'd2);
        bus_write(O_CTRL, 32'h5);
        irq_check(1'b1, "pre_rst_irq");
        reg_read(O_CNT, 32'h37, "pre_rst_count");
        rst_n = 1'b0;
        wait_cycles(1);
        rst_n = 1'b1;
        reg_read(O_CTRL, 32'd0, "rst_ctrl");
        reg_read(O_PRE, 32'd0, "rst_prescale");
        reg_read(O_CNT, 32'd0, "rst_count");
        reg_read(O_CMP, 32'd0, "rst_compare");
        reg_read(O_STS, 32'd0, "rst_status");
        irq_check(1'b0, "rst_irq");
        wait_cycles(5);
        reg_read(O_CNT, 32'd0, "rst_frozen");
        bus_write(O_CMP, 32'hFFFF_FFFF);
        bus_write(O_CTRL, 32'h1);
        wait_cycles(3);
        reg_read(O_CNT, 32'd3, "rst_restart");

        if (exp_q.size() != 0) begin
            tests_run++;
            fail_cnt++;
            $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
